// File: rtl/opl3_host_write_if.sv
// rtl/opl3_host_write_if.sv - OPL3 four-port host write front end with write FIFO and paced register-write issue
package opl3_host_write_if_pkg;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;

endpackage

module opl3_host_write_if
  import opl3_host_write_if_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_WR_GAP = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            host_wr,
  input  logic [1:0]                      host_addr,
  input  logic [7:0]                      host_data,
  output logic                            host_ready,
  output opl3_reg_wr_t                    opl3_reg_wr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pending,
  output logic                            fifo_overflow
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam int GW       = (MIN_WR_GAP > 1) ? $clog2(MIN_WR_GAP) : 1;
  localparam int GAP_LAST = (MIN_WR_GAP > 0) ? MIN_WR_GAP - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   gap_cnt;
  logic [GW-1:0]   gap_cnt_nxt;

  logic [7:0]      addr_latch;
  logic            bank_latch;

  // Entry layout: {bank, address, data}
  logic [16:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            data_wr;
  logic            push;
  logic            pop;

  assign host_ready = !reset && (count < CW'(FIFO_DEPTH));
  assign data_wr    = host_wr && host_addr[0];
  assign push       = data_wr && host_ready;
  assign pending    = count;

  // host_addr[1] doubles as the bank number for address-port writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_latch <= '0;
      bank_latch <= 1'b0;
    end else if (host_wr && !host_addr[0]) begin
      addr_latch <= host_data;
      bank_latch <= host_addr[1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bank_latch, addr_latch, host_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_overflow <= 1'b0;
    end else if (data_wr && !host_ready) begin
      fifo_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        gap_cnt_nxt = '0;
        state_nxt   = (MIN_WR_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_LAST)) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The pulse lasts exactly the ISSUE cycle; fields return to zero with valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      opl3_reg_wr <= '0;
    end else if (pop) begin
      opl3_reg_wr <= {1'b1, mem[rd_ptr]};
    end else begin
      opl3_reg_wr <= '0;
    end
  end

endmodule

// File: tb/tb_opl3_host_write_if.sv
// tb/tb_opl3_host_write_if.sv - directed bench for opl3_host_write_if
module tb_opl3_host_write_if;
  import opl3_host_write_if_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         host_wr = 1'b0;
  logic [1:0]   host_addr = 2'd0;
  logic [7:0]   host_data = 8'd0;
  logic         host_ready;
  opl3_reg_wr_t opl3_reg_wr;
  logic [4:0]   pending;
  logic         fifo_overflow;

  opl3_host_write_if #(
    .FIFO_DEPTH(16),
    .MIN_WR_GAP(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host_wr      (host_wr),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .host_ready   (host_ready),
    .opl3_reg_wr  (opl3_reg_wr),
    .pending      (pending),
    .fifo_overflow(fifo_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic       bank;
    logic [7:0] a;
    logic [7:0] d;
  } pulse_t;

  pulse_t      pq[$];
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (opl3_reg_wr.valid === 1'b1) begin
      pq.push_back('{cyc, opl3_reg_wr.bank_num, opl3_reg_wr.address, opl3_reg_wr.data});
    end else begin
      check("idle_fields_zero", 32'(opl3_reg_wr), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hw(input logic [1:0] a, input logic [7:0] d);
    host_wr   = 1'b1;
    host_addr = a;
    host_data = d;
    @(posedge clk);
    #1;
    host_wr   = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (pq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, pq.size(), n);
  endtask

  task automatic compare_all(input string tag);
    int m;
    check($sformatf("%s_count", tag), pq.size(), exp_q.size());
    m = (pq.size() < exp_q.size()) ? pq.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_pulse%0d", tag, i), {pq[i].bank, pq[i].a, pq[i].d}, exp_q[i]);
    end
  endtask

  initial begin
    int acc;

    // Reset state
    tick(3);
    check("rst_ready", host_ready, 0);
    check("rst_reg_wr", 32'(opl3_reg_wr), 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", fifo_overflow, 0);
    reset = 1'b0;
    tick(1);
    check("ready_after_rst", host_ready, 1);

    // Single bank-0 write
    hw(2'd0, 8'hBD);
    hw(2'd1, 8'h20);
    acc = cyc;
    check("single_pending1", pending, 1);
    wait_pulses(1, 20, "single_seen");
    if (pq.size() > 0) check("single_latency", pq[0].cyc, acc + 1);
    tick(20);
    exp_q = '{{1'b0, 8'hBD, 8'h20}};
    compare_all("single");
    check("single_pending0", pending, 0);
    pq.delete();

    // Bank 1 write
    hw(2'd2, 8'h05);
    hw(2'd1, 8'h01);
    wait_pulses(1, 20, "bank1_seen");
    tick(20);
    exp_q = '{{1'b1, 8'h05, 8'h01}};
    compare_all("bank1");
    pq.delete();

    // Backlog with latch reuse and pulse spacing
    hw(2'd0, 8'hC0);
    for (int i = 0; i < 5; i++) hw(2'd1, 8'h10 + 8'(i));
    wait_pulses(5, 60, "backlog_seen");
    tick(20);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 8'hC0, 8'h10 + 8'(i)});
    compare_all("backlog");
    if (pq.size() >= 5) begin
      for (int i = 1; i < 5; i++) check($sformatf("backlog_gap%0d", i), pq[i].cyc - pq[i-1].cyc, 6);
    end
    pq.delete();

    // Overflow: 20 back-to-back writes; the 20th meets a full FIFO
    check("ovf_pre_pending", pending, 0);
    check("ovf_pre_flag", fifo_overflow, 0);
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("ovf_ready%0d", i), host_ready, (i < 19) ? 1 : 0);
      hw(2'd1, 8'h40 + 8'(i));
      if (i < 19) exp_q.push_back({1'b0, 8'hC0, 8'h40 + 8'(i)});
    end
    check("ovf_flag", fifo_overflow, 1);
    wait_pulses(19, 200, "ovf_seen");
    tick(20);
    compare_all("ovf");
    check("ovf_pending0", pending, 0);
    check("ovf_flag_sticky", fifo_overflow, 1);
    pq.delete();

    // Reset mid-drain
    hw(2'd0, 8'h33);
    for (int i = 0; i < 8; i++) hw(2'd1, 8'h80 + 8'(i));
    hw(2'd2, 8'h99);
    wait_pulses(2, 30, "rstmid_seen");
    reset = 1'b1;
    tick(1);
    check("rstmid_ready_low", host_ready, 0);
    reset = 1'b0;
    check("rstmid_pending", pending, 0);
    check("rstmid_overflow", fifo_overflow, 0);
    check("rstmid_valid", 32'(opl3_reg_wr), 0);
    tick(40);
    check("rstmid_no_more", pq.size(), 2);
    hw(2'd1, 8'h77);
    wait_pulses(3, 20, "rstmid_new_seen");
    tick(20);
    exp_q = '{{1'b0, 8'h33, 8'h80}, {1'b0, 8'h33, 8'h81}, {1'b0, 8'h00, 8'h77}};
    compare_all("rstmid");
    pq.delete();

    // Wrap-around, paced on host_ready
    hw(2'd2, 8'hA5);
    exp_q.delete();
    for (int i = 0; i < 48; i++) begin
      int k;
      k = 0;
      while (!host_ready && k < 20) begin
        tick(1);
        k++;
      end
      hw(2'd1, 8'(i * 7));
      exp_q.push_back({1'b1, 8'hA5, 8'(i * 7)});
    end
    wait_pulses(48, 400, "wrap_seen");
    tick(20);
    compare_all("wrap");
    check("wrap_overflow", fifo_overflow, 0);
    check("wrap_pending0", pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
